arith_mc: RTL
=============

# arith_mc

Parametrised multi-cycle arithmetic unit for the BETA datapath. It performs single-cycle add and subtract, and W-cycle shift-add multiply in signed or unsigned form. Results are registered and reported with Z/V/N flags through a start/busy/done handshake. It sits beside the combinational adder in the execute stage and lets the control unit issue multiplies without lengthening the critical path.

## Interface
- WIDTH, 32, operand/result width in bits (≥4)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 ADD, 01 SUB, 10 MUL signed, 11 MULU unsigned
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- s  out  WIDTH  registered result
- z  out  1  result zero
- v  out  1  overflow
- n  out  1  result sign (s[WIDTH-1])
- busy  out  1  high in ITER and FIN
- done  out  1  one-cycle pulse: s/z/v/n updated this cycle

## Operation
- Reset: state IDLE; s=0, z=0, v=0, n=0, busy=0, done=0. Iteration counter and accumulator are cleared. Reset wins over every other event, including mid-multiply; that operation is aborted with no done.
- The FSM has three states: IDLE, ITER and FIN.
- IDLE with start=1 and op ADD/SUB:
  - Compute r = a+b or a−b, mod 2^WIDTH, and register it into s. Stay in IDLE.
  - Set z=(r==0) and n=r[W-1].
  - Set v=(a[W-1]==(b[W-1]^op[0])) && (r[W-1]!=a[W-1]).
  - Pulse done.
- IDLE with start=1 and op MUL/MULU:
  - Latch op.
  - Multiplicand/multiplier registers take |a| and |b| for MUL, or a and b raw for MULU.
  - Latch the product sign neg = a[W-1]^b[W-1] for MUL, 0 for MULU.
  - Clear the 2·WIDTH accumulator and set count=0. Go to ITER.
- ITER, one multiplier bit per cycle, LSB first:
  - If the current bit is 1, add the multiplicand shifted left by count into the accumulator.
  - After WIDTH cycles (count=WIDTH−1 processed), go to FIN.
- FIN:
  - p = neg ? −acc : acc, taken as a 2·WIDTH two's-complement value. Then s = p[W-1:0], z=(s==0), n=s[W-1].
  - v for MUL: p is not representable as signed WIDTH, i.e. p[2W-1:W-1] is neither all-0 nor all-1.
  - v for MULU: acc[2W-1:W] ≠ 0.
  - Pulse done and return to IDLE.
- Absolute value of the most negative value: |−2^(W-1)| = 2^(W-1), held as an unsigned WIDTH-bit magnitude. This is exact, with no wrap.
- start while busy=1 is ignored and not queued. a, b and op are don't-care after the accepting edge.
- s/z/v/n hold their last value until the next done. They are never partially updated during ITER.

## Timing
- ADD/SUB: accepted at edge E0. Results and done=1 are visible after E0, for exactly one cycle. Back-to-back issue is allowed, giving one ADD/SUB per cycle.
- MUL/MULU: accepted at E0, followed by ITER on edges E1..E(WIDTH) and FIN at E(WIDTH+1).
  - done and results are visible after E(WIDTH+1), so latency is WIDTH+1 cycles.
  - busy is high after E0 through E(WIDTH+1), then low in the done cycle.
- Done cycle: the FSM is already in IDLE, so a start in that cycle is accepted at the next edge. There is no dead cycle between operations.
- Reset asserted at any edge: outputs take reset values after that edge. done is never asserted in the cycle following a reset edge.

## Test plan
- Reset, then ADD a=0x7FFFFFFF, b=1: the next cycle shows s=0x80000000, v=1, n=1, z=0, done=1 for one cycle.
- SUB a=5, b=5, immediately followed by ADD a=0xFFFFFFFF, b=2 on the next cycle:
  - s=0 with z=1, v=0.
  - Then s=1, v=0.
  - done is high two consecutive cycles.
- MUL (WIDTH=32) a=−3 (0xFFFFFFFD), b=7:
  - busy is high for 33 cycles.
  - done comes 33 cycles after start, with s=0xFFFFFFEB, n=1, v=0, z=0.
  - start pulses issued during busy are ignored.
- WIDTH=8 instance:
  - MUL a=0x80, b=0xFF (−128×−1) → s=0x80, v=1, n=1.
  - MULU a=0x10, b=0x10 → s=0x00, z=1, v=1.
  - MULU a=0x0F, b=0x11 → s=0xFF, v=0.
- Start MUL a=6, b=7, then assert reset for one cycle at ITER cycle 10:
  - All outputs return to reset values and no done appears.
  - A subsequent ADD 2+3 gives s=5 one cycle after start.

Source files
------------

// File: rtl/arith_mc.sv
// Multi-cycle ALU: ADD/SUB results one cycle after start; MUL/MULU after WIDTH+1 cycles via shift-add.
// No backpressure: start is only taken in IDLE, and a start seen while busy is dropped without being queued.
module arith_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t               state, state_nxt;
    logic                 mulu;
    logic                 neg;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;

    logic [WIDTH-1:0]     r;
    logic                 r_v;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   p;
    logic [WIDTH:0]       p_hi;
    logic                 p_v;
    logic                 last_iter;

    always_comb begin
        r         = op[0] ? (a - b) : (a + b);
        r_v       = (a[WIDTH-1] == (b[WIDTH-1] ^ op[0])) && (r[WIDTH-1] != a[WIDTH-1]);
        // The negation of the most negative value reads back as 2^(W-1) unsigned, which is exact.
        abs_a     = a[WIDTH-1] ? -a : a;
        abs_b     = b[WIDTH-1] ? -b : b;
        p         = neg ? -acc : acc;
        p_hi      = p[2*WIDTH-1:WIDTH-1];
        p_v       = mulu ? (|acc[2*WIDTH-1:WIDTH]) : ((|p_hi) && !(&p_hi));
        last_iter = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && op[1]) state_nxt = ITER;
            ITER:    if (last_iter)      state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s      <= '0;
            z      <= 1'b0;
            v      <= 1'b0;
            n      <= 1'b0;
            done   <= 1'b0;
            mulu   <= 1'b0;
            neg    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !op[1]) begin
                        s    <= r;
                        z    <= (r == '0);
                        n    <= r[WIDTH-1];
                        v    <= r_v;
                        done <= 1'b1;
                    end else if (start) begin
                        mulu   <= op[0];
                        neg    <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand  <= {{WIDTH{1'b0}}, (op[0] ? a : abs_a)};
                        mplier <= op[0] ? b : abs_b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                ITER: begin
                    // Shifting both operands keeps the per-cycle add independent of count.
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                end
                FIN: begin
                    s    <= p[WIDTH-1:0];
                    z    <= (p[WIDTH-1:0] == '0);
                    n    <= p[WIDTH-1];
                    v    <= p_v;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule
